tod_counter_multi: RTL and testbench
====================================

// Module: tod_counter_multi
// PURPOSE
//  Parametrised time-of-day counter: seconds-of-day count from a clock prescaler,
//  signed-offset time adjust with live preview, direct load, N independent alarm channels.
//  Sits between the key/FSM controller and the display mux.
//  Generalises the single-alarm clock counter in tick rate, widths, alarm count and adjust mode.
// PARAMETERS
//  TICK_DIV    50_000_000  clk cycles per second tick (sim: small value)
//  SEC_PER_DAY 86400       seconds per day; count range 0..SEC_PER_DAY-1
//  CNT_W       17          width of seconds count (>= clog2(SEC_PER_DAY))
//  OFS_W       18          width of signed adjust offset (two's complement)
//  N_ALM       4           alarm channels (1..8)
//  WRAP_ADJ    1           1: adjust wraps modulo day; 0: adjust saturates at 0 / SEC_PER_DAY-1
//  SNOOZE_SEC  300         snooze interval in seconds (TOD_SNOOZE_EN only)
// PORTS
//  clk          in   1        system clock
//  rst          in   1        synchronous reset, active-high
//  run          in   1        1: count seconds; 0: hold count, prescaler held at 0
//  load_valid   in   1        load load_sec into count this cycle
//  load_sec     in   CNT_W    load value; values >= SEC_PER_DAY are ignored (no load)
//  adj_offset   in   OFS_W    signed offset applied to preview
//  adj_commit   in   1        copy preview_sec into count
//  alm_wr_en    in   1        write alarm channel alm_wr_idx
//  alm_wr_idx   in   3        alarm channel index; idx >= N_ALM ignored
//  alm_wr_sec   in   CNT_W    alarm time (seconds of day)
//  alm_wr_arm   in   1        arm bit written with alm_wr_sec
//  alm_ack      in   N_ALM    per-channel hit clear
//  alm_snooze   in   N_ALM    per-channel snooze request (ignored without TOD_SNOOZE_EN)
//  sec_cnt      out  CNT_W    current seconds of day
//  preview_sec  out  CNT_W    sec_cnt adjusted by adj_offset
//  time_bcd     out  24       BCD hhmmss of preview_sec
//  tick         out  1        one-cycle pulse per counted second
//  day_wrap     out  1        one-cycle pulse on SEC_PER_DAY-1 -> 0 rollover
//  alm_hit      out  N_ALM    latched per-channel alarm flags
// BEHAVIOUR
//  Reset: sec_cnt=0, preview_sec=0, time_bcd=0, tick=0, day_wrap=0, alm_hit=0, all alarms disarmed/0.
//  Prescaler: counts 0..TICK_DIV-1 while run=1; tick pulses on wrap (registered, 1 cycle).
//  Priority per cycle: rst > load_valid > adj_commit > tick increment. Load/commit clear prescaler.
//  Increment: sec_cnt+1; at SEC_PER_DAY-1 -> 0 with day_wrap pulse same cycle as update.
//  Preview: registered, 1-cycle latency; sum computed at CNT_W+OFS_W+1 bits signed.
//   WRAP_ADJ=1: result mod SEC_PER_DAY (negative adds SEC_PER_DAY; |offset|<SEC_PER_DAY required).
//   WRAP_ADJ=0: clamp to [0, SEC_PER_DAY-1].
//  Commit uses the preview_sec register value (offset sampled the cycle before).
//  time_bcd: 2-cycle latency from preview_sec via sub-module; hours 00..23 when SEC_PER_DAY=86400.
//  Alarm match: event when sec_cnt changes (tick, load or commit) and new value == armed channel time;
//   alm_hit[i] sets cycle after the update. Stays set until alm_ack[i].
//   ack and new match same cycle: match wins (hit stays 1). Write to channel clears its hit.
//  run=0 holds sec_cnt; no alarm events occur unless load/commit.
// CONFIGURATION
//  TOD_SNOOZE_EN defined: alm_snooze[i] while hit clears hit and loads per-channel countdown
//   SNOOZE_SEC; decremented on each tick; at 0 hit re-asserts. ack or channel write cancels countdown.
//  TOD_SNOOZE_EN undefined: alm_snooze ignored, no countdown registers; alarms fire only on match.
// STRUCTURE
//  Package tod_pkg: SEC_PER_DAY default, BCD digit type, alarm channel struct {sec, arm}.
//  Sub-module tod_sec2bcd: 2-stage pipeline, stage1 seconds->h/m/s binary, stage2 binary->BCD.
// TESTING
//  TICK_DIV=4, run=1 from reset: tick every 4 clk, sec_cnt 0,1,2.. ; hold run=0 -> sec_cnt frozen.
//  load_sec=86399, run=1: next tick sec_cnt=0 with day_wrap=1 one cycle; load 86400 -> no change.
//  sec_cnt=10, adj_offset=-20, WRAP_ADJ=1 -> preview 86390; WRAP_ADJ=0 -> preview 0; commit -> sec_cnt=preview.
//  ch2 armed at 100, load 99, tick -> alm_hit=4'b0100 next cycle; ack+rematch same cycle keeps hit.
//  TOD_SNOOZE_EN, SNOOZE_SEC=3: snooze on hit -> hit clears, re-asserts after 3 ticks; ack cancels.
//  load 45296 -> time_bcd=24'h123456 two cycles after preview_sec updates; rst mid-count -> all outputs 0.

Source files
------------

// File: rtl/tod_pkg.sv
// Shared types for the time-of-day counter: defaults, BCD digit, alarm channel record.
package tod_pkg;

   localparam int unsigned SEC_PER_DAY_DEF = 86400;
   localparam int unsigned ALM_SEC_W       = 32;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      logic [ALM_SEC_W-1:0] sec;
      logic                 arm;
   } alm_chan_t;

   // Two-digit BCD of a value 0..99.
   function automatic logic [7:0] to_bcd2(input logic [6:0] v);
      bcd_digit_t tens;
      bcd_digit_t ones;
      tens = 4'(v / 7'd10);
      ones = 4'(v % 7'd10);
      return {tens, ones};
   endfunction

endpackage

// File: rtl/tod_sec2bcd.sv
// Seconds-of-day to BCD hhmmss, two register stages (split, then BCD encode).
module tod_sec2bcd
   import tod_pkg::*;
#(
   parameter int unsigned CNT_W = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] sec_in,
   output logic [23:0]      bcd
);

   logic [31:0] s32;
   logic [6:0]  hh_q;
   logic [5:0]  mm_q;
   logic [5:0]  ss_q;

   assign s32 = 32'(sec_in);

   // Stage 1 splits into binary hours/minutes/seconds; stage 2 encodes BCD.
   always_ff @(posedge clk) begin
      if (rst) begin
         hh_q <= '0;
         mm_q <= '0;
         ss_q <= '0;
         bcd  <= '0;
      end else begin
         hh_q <= 7'((s32 / 32'd3600) % 32'd100);
         mm_q <= 6'((s32 % 32'd3600) / 32'd60);
         ss_q <= 6'(s32 % 32'd60);
         bcd  <= {to_bcd2(hh_q), to_bcd2({1'b0, mm_q}), to_bcd2({1'b0, ss_q})};
      end
   end

endmodule

// File: rtl/tod_counter_multi.sv
// Time-of-day counter with prescaler, signed adjust preview, load and N alarm channels.
// Optional snooze countdown per channel when TOD_SNOOZE_EN is defined.
module tod_counter_multi
   import tod_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 50_000_000,
   parameter int unsigned SEC_PER_DAY = SEC_PER_DAY_DEF,
   parameter int unsigned CNT_W       = 17,
   parameter int unsigned OFS_W       = 18,
   parameter int unsigned N_ALM       = 4,
   parameter bit          WRAP_ADJ    = 1'b1,
   parameter int unsigned SNOOZE_SEC  = 300
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             load_valid,
   input  logic [CNT_W-1:0] load_sec,
   input  logic [OFS_W-1:0] adj_offset,
   input  logic             adj_commit,
   input  logic             alm_wr_en,
   input  logic [2:0]       alm_wr_idx,
   input  logic [CNT_W-1:0] alm_wr_sec,
   input  logic             alm_wr_arm,
   input  logic [N_ALM-1:0] alm_ack,
   input  logic [N_ALM-1:0] alm_snooze,
   output logic [CNT_W-1:0] sec_cnt,
   output logic [CNT_W-1:0] preview_sec,
   output logic [23:0]      time_bcd,
   output logic             tick,
   output logic             day_wrap,
   output logic [N_ALM-1:0] alm_hit
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SUM_W = CNT_W + OFS_W + 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEC_PER_DAY - 1);
   localparam logic [CNT_W:0]   CNT_LIM  = (CNT_W+1)'(SEC_PER_DAY);
   localparam logic signed [SUM_W-1:0] SPD_S = SUM_W'(SEC_PER_DAY);

   logic [PRE_W-1:0]        presc_q, presc_nxt;
   logic [CNT_W-1:0]        cnt_nxt, prev_nxt;
   logic                    inc, upd, evt_q;
   logic signed [SUM_W-1:0] sum;
   alm_chan_t               chan_q   [N_ALM];
   alm_chan_t               chan_nxt [N_ALM];
   logic [N_ALM-1:0]        hit_nxt;

   // Next count/prescaler: load beats commit beats tick increment.
   always_comb begin
      cnt_nxt   = sec_cnt;
      presc_nxt = presc_q;
      inc       = 1'b0;
      upd       = 1'b0;
      if (load_valid && ({1'b0, load_sec} < CNT_LIM)) begin
         cnt_nxt   = load_sec;
         presc_nxt = '0;
         upd       = 1'b1;
      end else if (adj_commit) begin
         cnt_nxt   = preview_sec;
         presc_nxt = '0;
         upd       = 1'b1;
      end else if (!run) begin
         presc_nxt = '0;
      end else if (presc_q == PRE_LAST) begin
         presc_nxt = '0;
         inc       = 1'b1;
         upd       = 1'b1;
         cnt_nxt   = (sec_cnt == CNT_LAST) ? '0 : sec_cnt + 1'b1;
      end else begin
         presc_nxt = presc_q + 1'b1;
      end
   end

   // Preview: signed sum, then wrap modulo day or clamp into range.
   always_comb begin
      sum = $signed({{(OFS_W+1){1'b0}}, sec_cnt})
          + $signed({{(CNT_W+1){adj_offset[OFS_W-1]}}, adj_offset});
      prev_nxt = CNT_W'(sum);
      if (sum[SUM_W-1]) begin
         prev_nxt = WRAP_ADJ ? CNT_W'(sum + SPD_S) : '0;
      end else if (sum >= SPD_S) begin
         prev_nxt = WRAP_ADJ ? CNT_W'(sum - SPD_S) : CNT_LAST;
      end
   end

   // Count, prescaler, preview and strobe registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         sec_cnt     <= '0;
         presc_q     <= '0;
         preview_sec <= '0;
         tick        <= 1'b0;
         day_wrap    <= 1'b0;
         evt_q       <= 1'b0;
      end else begin
         sec_cnt     <= cnt_nxt;
         presc_q     <= presc_nxt;
         preview_sec <= prev_nxt;
         tick        <= inc;
         day_wrap    <= inc && (sec_cnt == CNT_LAST);
         evt_q       <= upd;
      end
   end

`ifdef TOD_SNOOZE_EN
   localparam int unsigned SNZ_W = $clog2(SNOOZE_SEC + 1);
   logic [SNZ_W-1:0] snz_cnt_q   [N_ALM];
   logic [SNZ_W-1:0] snz_cnt_nxt [N_ALM];
   logic [N_ALM-1:0] snz_act_q, snz_act_nxt;
`else
   logic unused_snooze;
   assign unused_snooze = ^alm_snooze;
`endif

   // Alarm channels: match on count update sets hit; ack clears unless rematch; write clears.
   always_comb begin
      chan_nxt = chan_q;
      hit_nxt  = alm_hit;
`ifdef TOD_SNOOZE_EN
      snz_cnt_nxt = snz_cnt_q;
      snz_act_nxt = snz_act_q;
`endif
      for (int unsigned i = 0; i < N_ALM; i++) begin
         logic match;
         match = evt_q && chan_q[i].arm && (chan_q[i].sec == ALM_SEC_W'(sec_cnt));
         hit_nxt[i] = (alm_hit[i] & ~alm_ack[i]) | match;
`ifdef TOD_SNOOZE_EN
         if (alm_snooze[i] && alm_hit[i]) begin
            hit_nxt[i]     = 1'b0;
            snz_act_nxt[i] = 1'b1;
            snz_cnt_nxt[i] = SNZ_W'(SNOOZE_SEC);
         end else if (alm_ack[i]) begin
            snz_act_nxt[i] = 1'b0;
         end else if (snz_act_q[i] && inc) begin
            if (snz_cnt_q[i] <= SNZ_W'(1)) begin
               hit_nxt[i]     = 1'b1;
               snz_act_nxt[i] = 1'b0;
            end else begin
               snz_cnt_nxt[i] = snz_cnt_q[i] - 1'b1;
            end
         end
`endif
         if (alm_wr_en && (32'(alm_wr_idx) == i)) begin
            chan_nxt[i].sec = ALM_SEC_W'(alm_wr_sec);
            chan_nxt[i].arm = alm_wr_arm;
            hit_nxt[i]      = 1'b0;
`ifdef TOD_SNOOZE_EN
            snz_act_nxt[i]  = 1'b0;
`endif
         end
      end
   end

   // Alarm state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         alm_hit <= '0;
         for (int unsigned i = 0; i < N_ALM; i++) chan_q[i] <= '0;
      end else begin
         alm_hit <= hit_nxt;
         chan_q  <= chan_nxt;
      end
   end

`ifdef TOD_SNOOZE_EN
   // Snooze countdown registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         snz_act_q <= '0;
         for (int unsigned i = 0; i < N_ALM; i++) snz_cnt_q[i] <= '0;
      end else begin
         snz_act_q <= snz_act_nxt;
         snz_cnt_q <= snz_cnt_nxt;
      end
   end
`endif

   tod_sec2bcd #(.CNT_W(CNT_W)) u_bcd (
      .clk    (clk),
      .rst    (rst),
      .sec_in (preview_sec),
      .bcd    (time_bcd)
   );

endmodule

// File: tb/tb_tod_counter_multi.sv
// Directed bench: wrapping-adjust instance (a) and clamping-adjust instance (b) share inputs.
module tb_tod_counter_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        load_valid = 1'b0;
   logic [16:0] load_sec = '0;
   logic [17:0] adj_offset = '0;
   logic        adj_commit = 1'b0;
   logic        alm_wr_en = 1'b0;
   logic [2:0]  alm_wr_idx = '0;
   logic [16:0] alm_wr_sec = '0;
   logic        alm_wr_arm = 1'b0;
   logic [3:0]  alm_ack = '0;
   logic [3:0]  alm_snooze = '0;

   logic [16:0] sec_cnt, preview_sec, sec_cnt_b, preview_sec_b;
   logic [23:0] time_bcd, time_bcd_b;
   logic        tick, day_wrap, tick_b, day_wrap_b;
   logic [3:0]  alm_hit, alm_hit_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   tod_counter_multi #(.TICK_DIV(4), .SEC_PER_DAY(86400), .CNT_W(17), .OFS_W(18),
                       .N_ALM(4), .WRAP_ADJ(1'b1), .SNOOZE_SEC(3)) dut_a (
      .clk(clk), .rst(rst), .run(run), .load_valid(load_valid), .load_sec(load_sec),
      .adj_offset(adj_offset), .adj_commit(adj_commit), .alm_wr_en(alm_wr_en),
      .alm_wr_idx(alm_wr_idx), .alm_wr_sec(alm_wr_sec), .alm_wr_arm(alm_wr_arm),
      .alm_ack(alm_ack), .alm_snooze(alm_snooze), .sec_cnt(sec_cnt),
      .preview_sec(preview_sec), .time_bcd(time_bcd), .tick(tick),
      .day_wrap(day_wrap), .alm_hit(alm_hit));

   tod_counter_multi #(.TICK_DIV(4), .SEC_PER_DAY(86400), .CNT_W(17), .OFS_W(18),
                       .N_ALM(4), .WRAP_ADJ(1'b0), .SNOOZE_SEC(3)) dut_b (
      .clk(clk), .rst(rst), .run(run), .load_valid(load_valid), .load_sec(load_sec),
      .adj_offset(adj_offset), .adj_commit(adj_commit), .alm_wr_en(alm_wr_en),
      .alm_wr_idx(alm_wr_idx), .alm_wr_sec(alm_wr_sec), .alm_wr_arm(alm_wr_arm),
      .alm_ack(alm_ack), .alm_snooze(alm_snooze), .sec_cnt(sec_cnt_b),
      .preview_sec(preview_sec_b), .time_bcd(time_bcd_b), .tick(tick_b),
      .day_wrap(day_wrap_b), .alm_hit(alm_hit_b));

   // Advance n rising edges, then settle 1 time unit past the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [16:0] v);
      load_valid = 1'b1; load_sec = v; step(1); load_valid = 1'b0;
   endtask

   task automatic wr_alm(input logic [2:0] idx, input logic [16:0] v, input logic arm);
      alm_wr_en = 1'b1; alm_wr_idx = idx; alm_wr_sec = v; alm_wr_arm = arm;
      step(1); alm_wr_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; run = 1'b0; step(2);
      n_cmp++; if (sec_cnt !== 17'd0) begin n_bad++; $display("FAIL rst_sec got %0d want 0", sec_cnt); end
      n_cmp++; if (preview_sec !== 17'd0) begin n_bad++; $display("FAIL rst_prev got %0d want 0", preview_sec); end
      n_cmp++; if (time_bcd !== 24'h0) begin n_bad++; $display("FAIL rst_bcd got %h want 0", time_bcd); end
      n_cmp++; if ({tick, day_wrap, alm_hit} !== 6'b0) begin n_bad++; $display("FAIL rst_flags got %b want 0", {tick, day_wrap, alm_hit}); end
      n_cmp++; if ({sec_cnt_b, preview_sec_b, time_bcd_b, tick_b, day_wrap_b, alm_hit_b} !== '0) begin
         n_bad++; $display("FAIL rst_b got %0d/%0d/%h/%b want all 0", sec_cnt_b, preview_sec_b, time_bcd_b, {tick_b, day_wrap_b, alm_hit_b}); end
   endtask

   task automatic test_count;
      rst = 1'b0; run = 1'b1;
      step(3);
      n_cmp++; if ({sec_cnt, tick} !== {17'd0, 1'b0}) begin n_bad++; $display("FAIL cnt_pre got %0d/%b want 0/0", sec_cnt, tick); end
      step(1);
      n_cmp++; if ({sec_cnt, tick} !== {17'd1, 1'b1}) begin n_bad++; $display("FAIL cnt_1 got %0d/%b want 1/1", sec_cnt, tick); end
      step(1);
      n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL tick_pulse got %b want 0", tick); end
      step(3);
      n_cmp++; if ({sec_cnt, tick} !== {17'd2, 1'b1}) begin n_bad++; $display("FAIL cnt_2 got %0d/%b want 2/1", sec_cnt, tick); end
      run = 1'b0; step(10);
      n_cmp++; if ({sec_cnt, tick} !== {17'd2, 1'b0}) begin n_bad++; $display("FAIL cnt_hold got %0d/%b want 2/0", sec_cnt, tick); end
      run = 1'b1; step(3);
      n_cmp++; if (sec_cnt !== 17'd2) begin n_bad++; $display("FAIL cnt_restart got %0d want 2", sec_cnt); end
      step(1);
      n_cmp++; if (sec_cnt !== 17'd3) begin n_bad++; $display("FAIL cnt_3 got %0d want 3", sec_cnt); end
      run = 1'b0;
   endtask

   task automatic test_wrap;
      load(17'd86399);
      n_cmp++; if ({sec_cnt, day_wrap} !== {17'd86399, 1'b0}) begin n_bad++; $display("FAIL load_last got %0d/%b want 86399/0", sec_cnt, day_wrap); end
      run = 1'b1; step(3);
      n_cmp++; if (sec_cnt !== 17'd86399) begin n_bad++; $display("FAIL wrap_pre got %0d want 86399", sec_cnt); end
      step(1);
      n_cmp++; if ({sec_cnt, day_wrap, tick} !== {17'd0, 2'b11}) begin n_bad++; $display("FAIL wrap got %0d/%b%b want 0/11", sec_cnt, day_wrap, tick); end
      run = 1'b0; step(1);
      n_cmp++; if (day_wrap !== 1'b0) begin n_bad++; $display("FAIL wrap_pulse got %b want 0", day_wrap); end
      load(17'd86400);
      n_cmp++; if (sec_cnt !== 17'd0) begin n_bad++; $display("FAIL load_oob got %0d want 0", sec_cnt); end
   endtask

   task automatic test_adjust;
      adj_offset = -18'd20;
      load(17'd10); step(1);
      n_cmp++; if (preview_sec !== 17'd86390) begin n_bad++; $display("FAIL prev_wrap_neg got %0d want 86390", preview_sec); end
      n_cmp++; if (preview_sec_b !== 17'd0) begin n_bad++; $display("FAIL prev_clamp_neg got %0d want 0", preview_sec_b); end
      adj_commit = 1'b1; step(1); adj_commit = 1'b0;
      n_cmp++; if (sec_cnt !== 17'd86390) begin n_bad++; $display("FAIL commit_a got %0d want 86390", sec_cnt); end
      n_cmp++; if (sec_cnt_b !== 17'd0) begin n_bad++; $display("FAIL commit_b got %0d want 0", sec_cnt_b); end
      adj_offset = 18'd10;
      load(17'd86395); step(1);
      n_cmp++; if (preview_sec !== 17'd5) begin n_bad++; $display("FAIL prev_wrap_pos got %0d want 5", preview_sec); end
      n_cmp++; if (preview_sec_b !== 17'd86399) begin n_bad++; $display("FAIL prev_clamp_pos got %0d want 86399", preview_sec_b); end
      adj_offset = 18'd0;
   endtask

   task automatic test_bcd;
      load(17'd45296); step(1);
      n_cmp++; if (preview_sec !== 17'd45296) begin n_bad++; $display("FAIL prev_zero got %0d want 45296", preview_sec); end
      step(2);
      n_cmp++; if (time_bcd !== 24'h123456) begin n_bad++; $display("FAIL bcd_123456 got %h want 123456", time_bcd); end
      load(17'd86399); step(3);
      n_cmp++; if (time_bcd_b !== 24'h235959) begin n_bad++; $display("FAIL bcd_235959 got %h want 235959", time_bcd_b); end
   endtask

   task automatic test_alarm;
      wr_alm(3'd2, 17'd100, 1'b1);
      load(17'd99); step(1);
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL alm_pre got %b want 0000", alm_hit); end
      run = 1'b1; step(4); run = 1'b0;
      n_cmp++; if ({sec_cnt, alm_hit} !== {17'd100, 4'b0000}) begin n_bad++; $display("FAIL alm_upd got %0d/%b want 100/0000", sec_cnt, alm_hit); end
      step(1);
      n_cmp++; if ({alm_hit, alm_hit_b} !== 8'b0100_0100) begin n_bad++; $display("FAIL alm_hit got %b/%b want 0100/0100", alm_hit, alm_hit_b); end
      load(17'd100); alm_ack = 4'b0100; step(1); alm_ack = 4'b0000;
      n_cmp++; if (alm_hit !== 4'b0100) begin n_bad++; $display("FAIL ack_rematch got %b want 0100", alm_hit); end
      alm_ack = 4'b0100; step(1); alm_ack = 4'b0000;
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL ack_clear got %b want 0000", alm_hit); end
      load(17'd100); step(1);
      n_cmp++; if (alm_hit !== 4'b0100) begin n_bad++; $display("FAIL alm_load got %b want 0100", alm_hit); end
      wr_alm(3'd2, 17'd100, 1'b1);
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL wr_clear got %b want 0000", alm_hit); end
      wr_alm(3'd2, 17'd100, 1'b0);
      load(17'd100); step(1);
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL disarmed got %b want 0000", alm_hit); end
      wr_alm(3'd6, 17'd100, 1'b1);
      load(17'd100); step(1);
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL bad_idx got %b want 0000", alm_hit); end
   endtask

   task automatic test_snooze;
      wr_alm(3'd2, 17'd100, 1'b1);
      load(17'd100); step(1);
      n_cmp++; if (alm_hit !== 4'b0100) begin n_bad++; $display("FAIL snz_setup got %b want 0100", alm_hit); end
`ifdef TOD_SNOOZE_EN
      alm_snooze = 4'b0100; step(1); alm_snooze = 4'b0000;
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL snz_clear got %b want 0000", alm_hit); end
      run = 1'b1; step(11);
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL snz_early got %b want 0000", alm_hit); end
      step(1); run = 1'b0;
      n_cmp++; if (alm_hit !== 4'b0100) begin n_bad++; $display("FAIL snz_refire got %b want 0100", alm_hit); end
      alm_snooze = 4'b0100; step(1); alm_snooze = 4'b0000;
      run = 1'b1; step(4);
      alm_ack = 4'b0100; step(1); alm_ack = 4'b0000;
      step(12); run = 1'b0;
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL snz_cancel got %b want 0000", alm_hit); end
`else
      alm_snooze = 4'b0100; step(1); alm_snooze = 4'b0000;
      n_cmp++; if (alm_hit !== 4'b0100) begin n_bad++; $display("FAIL snz_ignored got %b want 0100", alm_hit); end
      alm_ack = 4'b0100; step(1); alm_ack = 4'b0000;
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL snz_ack got %b want 0000", alm_hit); end
`endif
   endtask

   task automatic test_reset_mid;
      wr_alm(3'd2, 17'd100, 1'b1);
      load(17'd100); step(1);
      n_cmp++; if (alm_hit !== 4'b0100) begin n_bad++; $display("FAIL mid_setup got %b want 0100", alm_hit); end
      run = 1'b1; step(6);
      rst = 1'b1; step(1);
      n_cmp++; if ({sec_cnt, preview_sec, time_bcd, tick, day_wrap, alm_hit} !== '0) begin
         n_bad++; $display("FAIL mid_rst got %0d/%0d/%h/%b want all 0", sec_cnt, preview_sec, time_bcd, {tick, day_wrap, alm_hit}); end
      rst = 1'b0; run = 1'b0;
      load(17'd100); step(1);
      n_cmp++; if (alm_hit !== 4'b0000) begin n_bad++; $display("FAIL rst_disarm got %b want 0000", alm_hit); end
   endtask

   initial begin
      test_reset;
      test_count;
      test_wrap;
      test_adjust;
      test_bcd;
      test_alarm;
      test_snooze;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
